// File: rtl/mul_div_unit_divider.sv
// Iterative 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve without iterating.
module mul_div_unit_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q;
  logic [5:0]  count_q;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dmag_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  logic        is_signed;
  logic        is_rem;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        overflow;
  logic [31:0] special_res;
  logic [32:0] rem_tmp;
  logic        ge;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] fix_res;

  // Request decode: magnitudes, sign flags and special-case results.
  always_comb begin
    is_signed   = ~op[0];
    is_rem      = op[1];
    a_neg       = is_signed & dividend[31];
    b_neg       = is_signed & divisor[31];
    a_mag       = a_neg ? (32'd0 - dividend) : dividend;
    b_mag       = b_neg ? (32'd0 - divisor) : divisor;
    div_zero    = (divisor == 32'd0);
    overflow    = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    special_res = 32'd0;
    if (div_zero)
      special_res = is_rem ? dividend : 32'hFFFF_FFFF;
    else
      special_res = is_rem ? 32'd0 : 32'h8000_0000;
  end

  // Restoring step; the 33-bit partial remainder keeps large unsigned divisors exact.
  always_comb begin
    rem_tmp = {rem_q, quo_q[31]};
    ge      = (rem_tmp >= {1'b0, dmag_q});
    rem_d   = ge ? (rem_tmp[31:0] - dmag_q) : rem_tmp[31:0];
    quo_d   = {quo_q[30:0], ge};
    fix_res = 32'd0;
    if (op_q[1])
      fix_res = neg_rem_q ? (32'd0 - rem_q) : rem_q;
    else
      fix_res = neg_quo_q ? (32'd0 - quo_q) : quo_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 6'd0;
      op_q      <= 2'd0;
      rd_q      <= 5'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dmag_q    <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
      rd_out_q  <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            op_q      <= op;
            rd_q      <= rd_in;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (div_zero || overflow) begin
              result_q <= special_res;
              rd_out_q <= rd_in;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              rem_q   <= 32'd0;
              quo_q   <= a_mag;
              dmag_q  <= b_mag;
              count_q <= 6'd32;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            busy_q  <= 1'b0;
            count_q <= 6'd0;
            state_q <= IDLE;
          end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            count_q <= count_q - 6'd1;
            if (count_q == 6'd1)
              state_q <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          if (flush) begin
            state_q <= IDLE;
          end else begin
            result_q <= fix_res;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mul_div_unit_divider.sv
// Scoreboard bench for the RV32M divider: expected results queued at start, checked on done.
module tb_mul_div_unit_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  mul_div_unit_divider dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .rd_in(rd_in), .flush(flush),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0)
      r = o[1] ? a : 32'hFFFF_FFFF;
    else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      r = o[1] ? 32'd0 : 32'h8000_0000;
    else begin
      case (o)
        2'd0:    r = $signed(a) / $signed(b);
        2'd1:    r = a / b;
        2'd2:    r = $signed(a) % $signed(b);
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexp_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn cyc=%0d result=%h rd=%0d (exp %h rd=%0d)", cyc, result, rd_out, e.res, e.rd);
        chk("result", result, e.res);
        chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        chk("latency", cyc, e.cyc);
        chk("busy_w_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("timeout", 32'd0, 32'd1);
  endtask

  // Drives one request at a negedge; optionally queues the expected outcome.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit expect_it);
    exp_t e;
    bit special;
    special = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    start = 1'b1; op = o; dividend = a; divisor = b; rd_in = rd;
    if (expect_it) begin
      e.res = ref_div(o, a, b);
      e.rd  = rd;
      e.cyc = cyc + (special ? 1 : 34);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    dividend = 32'hDEAD_BEEF; divisor = 32'h1234_5678; rd_in = 5'd31;
    if (special) chk("special_busy", {31'd0, busy}, 32'd0);
    else         chk("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int snap;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(2'd1, 32'd100, 32'd7, 5'd5, 1'b1); wait_idle();
    issue(2'd3, 32'd100, 32'd7, 5'd6, 1'b1); wait_idle();
    issue(2'd0, 32'hFFFF_FF9C, 32'd7, 5'd7, 1'b1); wait_idle();
    issue(2'd2, 32'hFFFF_FF9C, 32'd7, 5'd8, 1'b1); wait_idle();
    issue(2'd0, 32'd100, 32'hFFFF_FFF9, 5'd9, 1'b1); wait_idle();
    issue(2'd2, 32'd100, 32'hFFFF_FFF9, 5'd10, 1'b1); wait_idle();
    issue(2'd0, 32'd42, 32'd0, 5'd11, 1'b1); wait_idle();
    issue(2'd3, 32'd42, 32'd0, 5'd12, 1'b1); wait_idle();
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1); wait_idle();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1); wait_idle();
    issue(2'd1, 32'hFFFF_FFFF, 32'h8000_0001, 5'd14, 1'b1); wait_idle();
    issue(2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 5'd15, 1'b1); wait_idle();

    // start re-presented mid-CALC must be ignored
    issue(2'd1, 32'd1000, 32'd3, 5'd16, 1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'd0; dividend = 32'd77; divisor = 32'd5; rd_in = 5'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // flush at cycle 20 aborts without done
    snap = done_cnt;
    issue(2'd1, 32'd5000, 32'd9, 5'd17, 1'b0);
    repeat (18) @(negedge clk);
    chk("busy_pre_flush", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy_post_flush", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_no_done", done_cnt, snap);

    issue(2'd1, 32'hFFFF_FFFF, 32'd1, 5'd18, 1'b1); wait_idle();

    // start together with flush in IDLE is ignored
    snap = done_cnt;
    start = 1'b1; flush = 1'b1; op = 2'd1; dividend = 32'd9; divisor = 32'd3; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("sf_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("sf_no_done", done_cnt, snap);

    for (int i = 0; i < 6; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, $urandom >> $urandom_range(0, 31),
            5'($urandom_range(0, 31)), 1'b1);
      wait_idle();
    end

    // asynchronous reset mid-CALC
    snap = done_cnt;
    issue(2'd1, 32'd123456, 32'd7, 5'd19, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_result", result, 32'd0);
    chk("ar_rd", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("ar_no_done", done_cnt, snap);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
